// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
//  Shared definitions for the accumulator control slice: FSM state encoding
//  and the default widths used by acc_ctrl and its neighbours.
// -----------------------------------------------------------------------------
package acc_pkg;

    // Default widths of the sample path, the integration length and frame count.
    localparam int ACC_DIN_WIDTH = 16;
    localparam int ACC_LEN_WIDTH = 32;
    localparam int ACC_CNT_WIDTH = 32;

    // Controller states; the encoding is fixed so software can read it back.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } acc_state_e;

endpackage : acc_pkg

// File: rtl/acc_ctrl.sv
// -----------------------------------------------------------------------------
// acc_ctrl
//  Sample/frame controller in front of unsigned accumulators. Delays the
//  sample by one clock, gates its qualifier to the RUN state and marks the
//  first sample of every integration with acc_done so each integration spans
//  exactly acc_len valid samples.
//
// Ports
//  clk          in   system clock
//  rst_n        in   asynchronous active-low reset
//  din          in   sample (passed through unmodified)
//  din_valid    in   sample qualifier
//  sync_in      in   alignment strobe, only honoured together with din_valid
//  en           in   1 = run, 0 = fall back to IDLE
//  acc_len      in   samples per integration, 0 behaves as 1
//  dout         out  din delayed one clock
//  dout_valid   out  din_valid delayed one clock, only while running
//  acc_done     out  first sample of an integration (always with dout_valid)
//  first_frame  out  with acc_done: the accumulator output is stale, discard
//  frame_cnt    out  completed integrations since entering RUN (wraps)
//  resync       out  sticky: sync_in arrived mid-integration; cleared in IDLE
// -----------------------------------------------------------------------------
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int DIN_WIDTH = ACC_DIN_WIDTH,
    parameter int LEN_WIDTH = ACC_LEN_WIDTH,
    parameter int CNT_WIDTH = ACC_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 sync_in,
    input  logic                 en,
    input  logic [LEN_WIDTH-1:0] acc_len,
    output logic [DIN_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 acc_done,
    output logic                 first_frame,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 resync
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] FCNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] FCNT_ZERO = {CNT_WIDTH{1'b0}};

    // A programmed length of zero would never close an integration; run it as 1.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        clamp_len = (len == LEN_ZERO) ? LEN_ONE : len;
    endfunction

    acc_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DIN_WIDTH-1:0]  dout_q;
    logic                  dout_valid_q, dout_valid_d;
    logic                  acc_done_q, acc_done_d;
    logic                  first_frame_q, first_frame_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic                  resync_q, resync_d;

    logic [LEN_WIDTH-1:0]  len_new_s;
    logic [LEN_WIDTH-1:0]  cnt_restart_s;

    // Length latched at a boundary and the counter value after that boundary
    // sample: with a length of 1 every sample is a boundary, so stay at 0.
    always_comb begin
        len_new_s     = clamp_len(acc_len);
        cnt_restart_s = (len_new_s == LEN_ONE) ? LEN_ZERO : LEN_ONE;
    end

    // Next-state and next-output logic, evaluated on the sample being presented.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        dout_valid_d  = 1'b0;
        acc_done_d    = 1'b0;
        first_frame_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        resync_d      = resync_q;

        case (state_q)
            IDLE: begin
                cnt_d       = LEN_ZERO;
                frame_cnt_d = FCNT_ZERO;
                resync_d    = 1'b0;
                if (en) begin
                    state_d = WAIT_SYNC;
                end else begin
                    state_d = IDLE;
                end
            end

            WAIT_SYNC: begin
                if (!en) begin
                    state_d     = IDLE;
                    frame_cnt_d = FCNT_ZERO;
                    resync_d    = 1'b0;
                end else if (din_valid && sync_in) begin
                    // The sync sample itself opens the first integration; the
                    // accumulator has nothing valid to report yet.
                    state_d       = RUN;
                    dout_valid_d  = 1'b1;
                    acc_done_d    = 1'b1;
                    first_frame_d = 1'b1;
                    cnt_d         = cnt_restart_s;
                    len_d         = len_new_s;
                end else begin
                    state_d = WAIT_SYNC;
                end
            end

            RUN: begin
                if (!en) begin
                    // Abandon the partial integration; this sample is dropped.
                    state_d     = IDLE;
                    frame_cnt_d = FCNT_ZERO;
                    resync_d    = 1'b0;
                end else if (din_valid) begin
                    dout_valid_d = 1'b1;
                    if ((cnt_q == LEN_ZERO) || sync_in) begin
                        // Regular boundary, or one forced early by sync_in.
                        acc_done_d  = 1'b1;
                        cnt_d       = cnt_restart_s;
                        len_d       = len_new_s;
                        frame_cnt_d = frame_cnt_q + FCNT_ONE;
                        if (cnt_q != LEN_ZERO) begin
                            resync_d = 1'b1;
                        end else begin
                            resync_d = resync_q;
                        end
                    end else if (cnt_q == (len_q - LEN_ONE)) begin
                        cnt_d = LEN_ZERO;
                    end else begin
                        cnt_d = cnt_q + LEN_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = LEN_ZERO;
                frame_cnt_d = FCNT_ZERO;
                resync_d    = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= LEN_ZERO;
            len_q         <= LEN_ONE;
            dout_q        <= {DIN_WIDTH{1'b0}};
            dout_valid_q  <= 1'b0;
            acc_done_q    <= 1'b0;
            first_frame_q <= 1'b0;
            frame_cnt_q   <= FCNT_ZERO;
            resync_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            dout_q        <= din;
            dout_valid_q  <= dout_valid_d;
            acc_done_q    <= acc_done_d;
            first_frame_q <= first_frame_d;
            frame_cnt_q   <= frame_cnt_d;
            resync_q      <= resync_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign acc_done    = acc_done_q;
    assign first_frame = first_frame_q;
    assign frame_cnt   = frame_cnt_q;
    assign resync      = resync_q;

endmodule : acc_ctrl
